alu_mul_ctrl: RTL

Multi-cycle 8x8 unsigned multiply sequencer that time-shares the 8-bit ALU with the CPU datapath. When idle, it passes CPU ALU requests straight through. When a multiply is started, it takes ownership of the ALU and sequences ADD and shift-right operations to build a 16-bit product. It then reports completion and result flags.

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_mul_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes, flag indices and multiplier FSM states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [3:0] {
        OP_SHR = 4'h0,
        OP_SHL = 4'h1,
        OP_INC = 4'h4,
        OP_DEC = 4'h5,
        OP_ADD = 4'h6,
        OP_NOT = 4'h8,
        OP_AND = 4'h9,
        OP_OR  = 4'ha,
        OP_XOR = 4'hb,
        OP_MOV = 4'hc
    } alu_op_e;

    localparam int FLAG_C = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        MS_IDLE = 3'd0,
        MS_ADD  = 3'd1,
        MS_SHH  = 3'd2,
        MS_SHL  = 3'd3,
        MS_DONE = 3'd4
    } mul_state_e;

    localparam logic [2:0] MUL_LAST_ITER = 3'd7;

    // {C,S,V,Z}: C and V both flag a product that no longer fits in 8 bits.
    function automatic logic [3:0] mul_flags(input logic [15:0] product);
        logic [3:0] f;
        f         = 4'h0;
        f[FLAG_C] = |product[15:8];
        f[FLAG_S] = product[15];
        f[FLAG_V] = |product[15:8];
        f[FLAG_Z] = ~|product;
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_ctrl.sv
// ============================================================================
// Module      : alu_mul_ctrl
// Description : 8x8 unsigned shift-add multiplier sequencer sharing the CPU ALU.
//               Optional macro ALU_MUL_SKIP_EN skips ADD for zero multiplier bits.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module alu_mul_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    input  logic [7:0]  mul_a_in,
    input  logic [7:0]  mul_b_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [15:0] product_out,
    output logic [3:0]  flags_out,
    input  logic [7:0]  cpu_a_in,
    input  logic [7:0]  cpu_b_in,
    input  logic [3:0]  cpu_op_in,
    input  logic [3:0]  cpu_status_in,
    output logic [7:0]  cpu_result_out,
    output logic [3:0]  cpu_status_out,
    output logic [7:0]  alu_a_out,
    output logic [7:0]  alu_b_out,
    output logic [3:0]  alu_op_out,
    output logic [3:0]  alu_status_out,
    input  logic [7:0]  alu_result_in,
    input  logic [3:0]  alu_status_in
);

    mul_state_e  state_q;
    logic [7:0]  m_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic        c_q;
    logic        s_q;
    logic [2:0]  cnt_q;
    logic [15:0] product_q;
    logic [3:0]  flags_q;
    logic        done_q;

    logic [7:0]  lo_d;
    logic [15:0] product_d;

    // The shifted-out bit of hi becomes the new MSB of lo.
    assign lo_d      = {s_q, alu_result_in[6:0]};
    assign product_d = {hi_q, lo_d};

    assign busy_out    = (state_q != MS_IDLE);
    assign done_out    = done_q;
    assign product_out = product_q;
    assign flags_out   = flags_q;

    always_comb begin
        alu_a_out      = 8'h00;
        alu_b_out      = 8'h00;
        alu_op_out     = OP_SHR;
        alu_status_out = 4'h0;
        cpu_result_out = 8'h00;
        cpu_status_out = 4'h0;
        case (state_q)
            MS_IDLE: begin
                alu_a_out      = cpu_a_in;
                alu_b_out      = cpu_b_in;
                alu_op_out     = cpu_op_in;
                alu_status_out = cpu_status_in;
                cpu_result_out = alu_result_in;
                cpu_status_out = alu_status_in;
            end
            MS_ADD: begin
                alu_op_out = OP_ADD;
                alu_a_out  = hi_q;
                alu_b_out  = lo_q[0] ? m_q : 8'h00;
            end
            MS_SHH: begin
                alu_op_out = OP_SHR;
                alu_a_out  = hi_q;
            end
            MS_SHL: begin
                alu_op_out = OP_SHR;
                alu_a_out  = lo_q;
            end
            default: begin
                alu_op_out = OP_SHR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MS_IDLE;
            m_q       <= 8'h00;
            hi_q      <= 8'h00;
            lo_q      <= 8'h00;
            c_q       <= 1'b0;
            s_q       <= 1'b0;
            cnt_q     <= 3'd0;
            product_q <= 16'h0000;
            flags_q   <= 4'h0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MS_IDLE: begin
                    if (start_in) begin
                        m_q   <= mul_a_in;
                        lo_q  <= mul_b_in;
                        hi_q  <= 8'h00;
                        cnt_q <= 3'd0;
                        c_q   <= 1'b0;
`ifdef ALU_MUL_SKIP_EN
                        state_q <= mul_b_in[0] ? MS_ADD : MS_SHH;
`else
                        state_q <= MS_ADD;
`endif
                    end
                end
                MS_ADD: begin
                    hi_q    <= alu_result_in;
                    c_q     <= alu_status_in[FLAG_C];
                    state_q <= MS_SHH;
                end
                MS_SHH: begin
                    hi_q    <= {c_q, alu_result_in[6:0]};
                    s_q     <= alu_status_in[FLAG_C];
                    state_q <= MS_SHL;
                end
                MS_SHL: begin
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == MUL_LAST_ITER) begin
                        product_q <= product_d;
                        flags_q   <= mul_flags(product_d);
                        done_q    <= 1'b1;
                        state_q   <= MS_DONE;
                    end else begin
`ifdef ALU_MUL_SKIP_EN
                        // lo_q[1] is the multiplier bit that lands in lo[0] after this shift.
                        if (!lo_q[1]) begin
                            c_q     <= 1'b0;
                            state_q <= MS_SHH;
                        end else begin
                            state_q <= MS_ADD;
                        end
`else
                        state_q <= MS_ADD;
`endif
                    end
                end
                MS_DONE: begin
                    state_q <= MS_IDLE;
                end
                default: begin
                    state_q <= MS_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
